rssb_loader: RTL

- Program loader on the write side of the RSSB data memory.
- Accepts a word stream over a valid/ready handshake and writes it into the memory from address 0 upward.
- Holds the RSSB core in reset while loading; releases the core once the last word is written.
- Sits between an external host/stream source and the core's memory write port; a mux outside this block selects loader vs. core write port using core_rst.

---
 rtl/rssb_loader.sv | 109 ++++++++++
 1 files changed

// File: rtl/rssb_loader.sv
// rssb_loader: program loader on the write side of the RSSB data memory.
// Takes a valid/ready word stream and writes it into memory from address 0
// upward. The core is held in reset while loading and released once the
// last word has been written.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start               single-cycle (re)load request
//   in_valid/in_data/in_last/in_ready   input word stream
//   mem_write/mem_addr/mem_wdata        memory write port (registered)
//   core_rst            active-low core reset (0 = core held)
//   done                program loaded, core running
//   err                 memory filled without in_last
//   word_count          words written in the current/last load
module rssb_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             core_rst,
    output logic             done,
    output logic             err,
    output logic [WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic             xfer;
    logic             restart;
    logic             at_top;
    logic [WIDTH-1:0] ptr;

    // The write pointer is the low part of word_count: both start at zero and
    // advance together, and the pointer never has to wrap because reaching
    // the top address without in_last ends the load.
    assign ptr      = word_count[WIDTH-1:0];
    assign at_top   = &ptr;
    assign in_ready = (state == LOAD);
    assign xfer     = in_valid && (state == LOAD);
    assign restart  = start && (state inside {IDLE, RUN, ERROR});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD: begin
                if (xfer) begin
                    if (in_last)     state_nxt = RELEASE;
                    else if (at_top) state_nxt = ERROR;
                end
            end
            RELEASE: state_nxt = RUN;
            RUN:     if (start) state_nxt = LOAD;
            ERROR:   if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            mem_write <= xfer;
            if (xfer) begin
                mem_addr   <= ptr;
                mem_wdata  <= in_data;
                word_count <= word_count + (WIDTH+1)'(1);
            end
            if (restart) begin
                word_count <= '0;
                err        <= 1'b0;
            end
            if (xfer && !in_last && at_top) err <= 1'b1;
            // Keyed off the next state: core_rst rises only on entry to RUN,
            // one cycle after the final write, and drops on the same edge a
            // reload leaves RUN.
            core_rst <= (state_nxt == RUN);
            done     <= (state_nxt == RUN);
        end
    end

endmodule
